// File: rtl/npu_message_service_defines.sv
// rtl/npu_message_service_defines.sv - shared service message types and tile constants
package npu_message_service_defines;

  localparam int TILE_COUNT        = 4;
  localparam int TILE_INDEX_W      = $clog2(TILE_COUNT);
  localparam int SERVICE_PAYLOAD_W = 32;

  // The numeric type value doubles as the core-side consumer index.
  typedef enum logic [1:0] {
    SVC_MSG_SYNC     = 2'd0,
    SVC_MSG_DMA_DONE = 2'd1,
    SVC_MSG_IRQ      = 2'd2,
    SVC_MSG_RESERVED = 2'd3
  } service_message_type_t;

  typedef struct packed {
    service_message_type_t         message_type;
    logic [TILE_INDEX_W-1:0]       src_tile;
    logic [SERVICE_PAYLOAD_W-1:0]  payload;
  } service_message_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with combinational head and almost-full flag
// SIZE must be a power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH                 = 8,
  parameter int SIZE                  = 4,
  parameter int ALMOST_FULL_THRESHOLD = SIZE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enqueue_en,
  input  logic [WIDTH-1:0] enqueue_value,
  input  logic             dequeue_en,
  output logic [WIDTH-1:0] dequeue_value,
  output logic             full,
  output logic             almost_full,
  output logic             empty
);

  localparam int PTR_W = $clog2(SIZE);
  localparam int CNT_W = $clog2(SIZE + 1);

  logic [WIDTH-1:0] storage [SIZE];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             do_enqueue;
  logic             do_dequeue;

  assign empty       = (count == '0);
  assign full        = (count == CNT_W'(SIZE));
  assign almost_full = (count >= CNT_W'(ALMOST_FULL_THRESHOLD));

  // A pop frees a slot in the same cycle, so a push at full is accepted alongside it.
  assign do_dequeue    = dequeue_en && !empty;
  assign do_enqueue    = enqueue_en && (!full || do_dequeue);
  assign dequeue_value = storage[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_enqueue) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_dequeue) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_enqueue, do_dequeue})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_enqueue) storage[wr_ptr] <= enqueue_value;
  end

endmodule

// File: rtl/n2c_service_dispatcher.sv
// rtl/n2c_service_dispatcher.sv - routes virtual-network service messages to core-side consumers
// Optional N2C_DROP_COUNTER_EN adds the saturating drop_count output.
module n2c_service_dispatcher
  import npu_message_service_defines::*;
#(
  parameter int NUM_CONSUMERS  = 3,
  parameter int INDEX_CONSUMER = 2
) (
  input  logic                                  clk,
  input  logic                                  reset,
  output logic                                  network_available,
  input  service_message_t                      message_in,
  input  logic                                  message_in_valid,
  output service_message_t [NUM_CONSUMERS-1:0]  n2c_message_out,
  output logic [NUM_CONSUMERS-1:0]              n2c_message_out_valid,
  input  logic [NUM_CONSUMERS-1:0]              n2c_consumer_ready
`ifdef N2C_DROP_COUNTER_EN
  ,
  output logic [15:0]                           drop_count
`endif
);

  localparam logic [0:0] STATE_EMPTY = 1'b0;
  localparam logic [0:0] STATE_HOLD  = 1'b1;

  logic [0:0]                state;
  logic [0:0]                state_nxt;
  service_message_t          head;
  service_message_t          out_msg;
  logic [INDEX_CONSUMER-1:0] head_target;
  logic [INDEX_CONSUMER-1:0] out_target;
  logic                      fifo_full;
  logic                      fifo_almost_full;
  logic                      fifo_empty;
  logic                      enqueue;
  logic                      dequeue;
  logic                      head_routable;
  logic                      load;
  logic                      discard;
  logic                      transfer;

  // Arrivals at full are discarded here rather than relying on the FIFO's pop bypass.
  assign enqueue = message_in_valid && !fifo_full;

  sync_fifo #(
    .WIDTH                ($bits(service_message_t)),
    .SIZE                 (4),
    .ALMOST_FULL_THRESHOLD(2)
  ) input_queue (
    .clk          (clk),
    .reset        (reset),
    .enqueue_en   (enqueue),
    .enqueue_value(message_in),
    .dequeue_en   (dequeue),
    .dequeue_value(head),
    .full         (fifo_full),
    .almost_full  (fifo_almost_full),
    .empty        (fifo_empty)
  );

  assign network_available = !fifo_almost_full;

  assign head_routable = (32'(head.message_type) < 32'(NUM_CONSUMERS));
  assign head_target   = INDEX_CONSUMER'(head.message_type);

  // Only the target's valid bit can be high, so ready on any other consumer is masked out.
  assign transfer = |(n2c_message_out_valid & n2c_consumer_ready);
  assign load     = !fifo_empty && head_routable && ((state == STATE_EMPTY) || transfer);
  assign discard  = !fifo_empty && !head_routable && (state == STATE_EMPTY);
  assign dequeue  = load || discard;

  always_comb begin
    state_nxt = state;
    case (state)
      STATE_EMPTY: if (load) state_nxt = STATE_HOLD;
      STATE_HOLD:  if (transfer && !load) state_nxt = STATE_EMPTY;
      default:     state_nxt = STATE_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= STATE_EMPTY;
      out_msg    <= '0;
      out_target <= '0;
    end else begin
      state <= state_nxt;
      if (load) begin
        out_msg    <= head;
        out_target <= head_target;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CONSUMERS; i++) begin
      n2c_message_out[i]       = out_msg;
      n2c_message_out_valid[i] = (state == STATE_HOLD) && (out_target == INDEX_CONSUMER'(i));
    end
  end

`ifdef N2C_DROP_COUNTER_EN
  logic [1:0]  drop_incr;
  logic [16:0] drop_sum;

  // A full-queue drop and an unroutable discard can coincide, adding two at once.
  assign drop_incr = {1'b0, message_in_valid && fifo_full} + {1'b0, discard};
  assign drop_sum  = {1'b0, drop_count} + {15'b0, drop_incr};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_count <= '0;
    end else begin
      drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end
`endif

endmodule
